// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration frame loader.
//   - Opcode constants for command words.
//   - Loader state enum.
//   - Command field positions plus small helpers to extract them.
package config_loader_pkg;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 28;
  localparam int unsigned IDX_MSB = 4;
  localparam int unsigned IDX_LSB = 0;
  localparam int unsigned OP_W    = OP_MSB - OP_LSB + 1;
  localparam int unsigned IDX_W   = IDX_MSB - IDX_LSB + 1;

  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_WRITE  = 4'h1;
  localparam logic [OP_W-1:0] OP_CLRERR = 4'h2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  function automatic logic [OP_W-1:0] get_opcode(input logic [31:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [31:0] word);
    return word[IDX_MSB:IDX_LSB];
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a frame index plus an enable into a one-hot strobe vector.
// The vector is all zero when the enable is low or the index is out of range.
// Ports:
//   idx     in  IDX_W       frame index
//   en      in  1           decode enable
//   onehot  out MAX_FRAMES  one-hot (or zero) strobe pattern
module frame_strobe_decoder
  import config_loader_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = 20
) (
  input  logic [IDX_W-1:0]      idx,
  input  logic                  en,
  output logic [MAX_FRAMES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < MAX_FRAMES; i++) begin
      if (en && (32'(idx) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/config_frame_loader.sv
// Sequences writes into the fabric configuration latch array.
// A WRITE command selects a frame, the next accepted word is the frame data.
// Data is driven one cycle before the strobe (SETUP) and held one cycle after
// it drops (HOLD), so latch data never moves while any strobe is high.
// Handshake: a word transfers on a rising CLK edge where in_valid and in_ready
// are both high; in_ready depends only on state, never on in_valid.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   in_data      command or data word
//   in_valid     in_data is valid
//   in_ready     loader accepts a word this cycle (IDLE or DATA)
//   FrameData    registered data to the latch column
//   FrameStrobe  registered latch enables, one-hot or zero
//   busy         loader is not idle
//   err          sticky error (bad index or undefined opcode)
//   frame_count  completed frame writes, wraps silently
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned FRAME_BITS    = 32,
  parameter int unsigned MAX_FRAMES    = 20,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  busy,
  output logic                  err,
  output logic [CNT_W-1:0]      frame_count
);

  // Counter only needs to hold STROBE_CYCLES-1.
  localparam int unsigned SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  state_t                  state;
  logic [IDX_W-1:0]        idx_q;
  logic [SCW-1:0]          strobe_cnt;
  logic [MAX_FRAMES-1:0]   dec_vec;
  logic [IDX_W-1:0]        cmd_idx;
  logic                    idx_ok;

  assign cmd_idx  = get_idx(in_data);
  assign idx_ok   = 32'(cmd_idx) < MAX_FRAMES;
  assign in_ready = (state == ST_IDLE) || (state == ST_DATA);
  assign busy     = (state != ST_IDLE);

  frame_strobe_decoder #(.MAX_FRAMES(MAX_FRAMES)) u_decoder (
    .idx    (idx_q),
    .en     (state == ST_SETUP),
    .onehot (dec_vec)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      strobe_cnt  <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      err         <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            case (get_opcode(in_data))
              OP_NOP: ;
              OP_WRITE: begin
                // An out-of-range write is dropped whole: no data word follows.
                if (idx_ok) begin
                  idx_q <= cmd_idx;
                  state <= ST_DATA;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_CLRERR: err <= 1'b0;
              default:   err <= 1'b1;
            endcase
          end
        end
        ST_DATA: begin
          // Any word here is data; no opcode decode.
          if (in_valid) begin
            FrameData <= in_data[FRAME_BITS-1:0];
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          FrameStrobe <= dec_vec;
          strobe_cnt  <= SCW'(STROBE_CYCLES - 1);
          state       <= ST_STROBE;
        end
        ST_STROBE: begin
          if (strobe_cnt == '0) begin
            FrameStrobe <= '0;
            frame_count <= frame_count + CNT_W'(1);
            state       <= ST_HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - SCW'(1);
          end
        end
        ST_HOLD: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader.
// dut_a: default parameters (STROBE_CYCLES=1, CNT_W=16).
// dut_b: STROBE_CYCLES=3 and CNT_W=2 so counter wrap is reachable quickly.
// Inputs are driven and outputs sampled on the falling edge.
module tb_config_frame_loader;

  logic clk;
  logic rst_a, rst_b;

  logic [31:0] a_in;
  logic        a_valid, a_ready, a_busy, a_err;
  logic [31:0] a_data;
  logic [19:0] a_strobe;
  logic [15:0] a_count;

  logic [31:0] b_in;
  logic        b_valid, b_ready, b_busy, b_err;
  logic [31:0] b_data;
  logic [19:0] b_strobe;
  logic [1:0]  b_count;

  int n_cmp;
  int n_bad;

  config_frame_loader dut_a (
    .CLK         (clk),
    .RST         (rst_a),
    .in_data     (a_in),
    .in_valid    (a_valid),
    .in_ready    (a_ready),
    .FrameData   (a_data),
    .FrameStrobe (a_strobe),
    .busy        (a_busy),
    .err         (a_err),
    .frame_count (a_count)
  );

  config_frame_loader #(.STROBE_CYCLES(3), .CNT_W(2)) dut_b (
    .CLK         (clk),
    .RST         (rst_b),
    .in_data     (b_in),
    .in_valid    (b_valid),
    .in_ready    (b_ready),
    .FrameData   (b_data),
    .FrameStrobe (b_strobe),
    .busy        (b_busy),
    .err         (b_err),
    .frame_count (b_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariant watchers: at most one strobe, and data never moves while a
  // strobe is high on either side of the change. Cycles around reset skipped.
  logic [31:0] a_prev_data, b_prev_data;
  logic [19:0] a_prev_strobe, b_prev_strobe;
  logic        a_rst_pend = 1'b1;
  logic        b_rst_pend = 1'b1;

  always @(negedge clk) begin
    #1;
    if (rst_a || a_rst_pend) begin
      a_rst_pend = rst_a;
    end else begin
      n_cmp++;
      if ($countones(a_strobe) > 1 ||
          (a_data !== a_prev_data && (a_strobe != 0 || a_prev_strobe != 0))) begin
        n_bad++;
        $display("FAIL a_invariant: strobe=%h data=%h prev_data=%h prev_strobe=%h",
                 a_strobe, a_data, a_prev_data, a_prev_strobe);
      end
    end
    a_prev_data   = a_data;
    a_prev_strobe = a_strobe;
  end

  always @(negedge clk) begin
    #1;
    if (rst_b || b_rst_pend) begin
      b_rst_pend = rst_b;
    end else begin
      n_cmp++;
      if ($countones(b_strobe) > 1 ||
          (b_data !== b_prev_data && (b_strobe != 0 || b_prev_strobe != 0))) begin
        n_bad++;
        $display("FAIL b_invariant: strobe=%h data=%h prev_data=%h prev_strobe=%h",
                 b_strobe, b_data, b_prev_data, b_prev_strobe);
      end
    end
    b_prev_data   = b_data;
    b_prev_strobe = b_strobe;
  end

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic send_a(input logic [31:0] w);
    a_valid = 1'b1;
    a_in    = w;
    @(negedge clk);
    a_valid = 1'b0;
    a_in    = '0;
  endtask

  task automatic send_b(input logic [31:0] w);
    b_valid = 1'b1;
    b_in    = w;
    @(negedge clk);
    b_valid = 1'b0;
    b_in    = '0;
  endtask

  task automatic test_reset();
    n_cmp++; if (a_data !== 32'h0) begin n_bad++; $display("FAIL rst_a_data: got %h want 0", a_data); end
    n_cmp++; if (a_strobe !== 20'h0) begin n_bad++; $display("FAIL rst_a_strobe: got %h want 0", a_strobe); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_a_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rst_a_err: got %b want 0", a_err); end
    n_cmp++; if (a_count !== 16'h0) begin n_bad++; $display("FAIL rst_a_count: got %h want 0", a_count); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_a_ready: got %b want 1", a_ready); end
    n_cmp++; if (b_count !== 2'h0) begin n_bad++; $display("FAIL rst_b_count: got %h want 0", b_count); end
    n_cmp++; if (b_strobe !== 20'h0) begin n_bad++; $display("FAIL rst_b_strobe: got %h want 0", b_strobe); end
  endtask

  task automatic test_single_write();
    send_a(32'h1000_0003);
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL wr_data_busy: got %b want 1", a_busy); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL wr_data_ready: got %b want 1", a_ready); end
    send_a(32'hDEAD_BEEF);
    n_cmp++; if (a_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_setup_data: got %h want deadbeef", a_data); end
    n_cmp++; if (a_strobe !== 20'h0) begin n_bad++; $display("FAIL wr_setup_strobe: got %h want 0", a_strobe); end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL wr_setup_ready: got %b want 0", a_ready); end
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h00008) begin n_bad++; $display("FAIL wr_strobe: got %h want 00008", a_strobe); end
    n_cmp++; if (a_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_strobe_data: got %h want deadbeef", a_data); end
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h0) begin n_bad++; $display("FAIL wr_hold_strobe: got %h want 0", a_strobe); end
    n_cmp++; if (a_count !== 16'd1) begin n_bad++; $display("FAIL wr_count: got %0d want 1", a_count); end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL wr_hold_ready: got %b want 0", a_ready); end
    @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL wr_idle_ready: got %b want 1", a_ready); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL wr_idle_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_errors();
    send_a(32'h1000_0014);
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL bad_idx_err: got %b want 1", a_err); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL bad_idx_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_strobe !== 20'h0) begin n_bad++; $display("FAIL bad_idx_strobe: got %h want 0", a_strobe); end
    // next word must be decoded as a command, not data
    send_a(32'h1000_0005);
    n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL after_bad_cmd_busy: got %b want 1", a_busy); end
    send_a(32'h1234_5678);
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h00020) begin n_bad++; $display("FAIL after_bad_strobe: got %h want 00020", a_strobe); end
    @(negedge clk);
    n_cmp++; if (a_count !== 16'd2) begin n_bad++; $display("FAIL after_bad_count: got %0d want 2", a_count); end
    @(negedge clk);
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", a_err); end
    send_a(32'h2000_0000);
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL clrerr: got %b want 0", a_err); end
    send_a(32'h3000_0000);
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL undef_op_err: got %b want 1", a_err); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL undef_op_busy: got %b want 0", a_busy); end
    send_a(32'h2000_0000);
    send_a(32'h0000_0000);
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL nop_err: got %b want 0", a_err); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL nop_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_reset_mid_strobe();
    send_a(32'h1000_0007);
    send_a(32'h0000_00AA);
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h00080) begin n_bad++; $display("FAIL pre_rst_strobe: got %h want 00080", a_strobe); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_cmp++; if (a_strobe !== 20'h0) begin n_bad++; $display("FAIL mid_rst_strobe: got %h want 0", a_strobe); end
    n_cmp++; if (a_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got %h want 0", a_data); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", a_count); end
    send_a(32'h1000_0002);
    send_a(32'h0F0F_0F0F);
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h00004) begin n_bad++; $display("FAIL post_rst_strobe: got %h want 00004", a_strobe); end
    @(negedge clk);
    n_cmp++; if (a_count !== 16'd1) begin n_bad++; $display("FAIL post_rst_count: got %0d want 1", a_count); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    send_a(32'h1000_0013);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_busy !== 1'b1 || a_strobe !== 20'h0 || a_data !== 32'h0F0F_0F0F || a_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_%0d: busy=%b strobe=%h data=%h ready=%b want 1/0/0f0f0f0f/1",
                 i, a_busy, a_strobe, a_data, a_ready);
      end
    end
    send_a(32'hCAFE_F00D);
    n_cmp++; if (a_data !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL stall_data: got %h want cafef00d", a_data); end
    @(negedge clk);
    n_cmp++; if (a_strobe !== 20'h80000) begin n_bad++; $display("FAIL stall_strobe: got %h want 80000", a_strobe); end
    @(negedge clk);
    n_cmp++; if (a_count !== 16'd2) begin n_bad++; $display("FAIL stall_count: got %0d want 2", a_count); end
    @(negedge clk);
  endtask

  task automatic test_long_strobe_and_wrap();
    send_b(32'h1000_0000);
    send_b(32'h0000_0005);
    n_cmp++; if (b_data !== 32'h5) begin n_bad++; $display("FAIL long_setup_data: got %h want 5", b_data); end
    n_cmp++; if (b_strobe !== 20'h0) begin n_bad++; $display("FAIL long_setup_strobe: got %h want 0", b_strobe); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b_strobe !== 20'h1 || b_data !== 32'h5) begin
        n_bad++;
        $display("FAIL long_strobe_%0d: strobe=%h data=%h want 1/5", i, b_strobe, b_data);
      end
    end
    @(negedge clk);
    n_cmp++; if (b_strobe !== 20'h0) begin n_bad++; $display("FAIL long_hold_strobe: got %h want 0", b_strobe); end
    n_cmp++; if (b_data !== 32'h5) begin n_bad++; $display("FAIL long_hold_data: got %h want 5", b_data); end
    n_cmp++; if (b_count !== 2'd1) begin n_bad++; $display("FAIL long_count: got %0d want 1", b_count); end
    n_cmp++; if (b_busy !== 1'b1) begin n_bad++; $display("FAIL long_hold_busy: got %b want 1", b_busy); end
    @(negedge clk);
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL long_idle_busy: got %b want 0", b_busy); end
    // three more writes: count goes 2, 3, then wraps to 0
    for (int w = 1; w <= 3; w++) begin
      send_b(32'h1000_0000 | 32'(w));
      send_b(32'h0000_0100 | 32'(w));
      repeat (4) @(negedge clk);
      n_cmp++;
      if (b_count !== 2'((w + 1) % 4)) begin
        n_bad++;
        $display("FAIL wrap_count_%0d: got %0d want %0d", w, b_count, (w + 1) % 4);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_in    = '0;
    b_in    = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_single_write();
    test_errors();
    test_reset_mid_strobe();
    test_stall();
    test_long_strobe_and_wrap();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
